// File: rtl/gmii_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gmii_rx_pkg
//  Purpose  : Shared definitions for the GMII receive deframer and the
//             CRC-32 byte engine (state encodings, framing and CRC
//             constants, status bit positions).
//  Revision : 1.0 - initial release
// ============================================================================
package gmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_DISCARD  = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PREAMBLE = 2'd2,
    ST_DATA     = 2'd3
  } rx_state_t;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [7:0]  PRE         = 8'h55;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  // status = {rx_er_seen, len_bad, crc_bad}
  localparam int STAT_W       = 3;
  localparam int STAT_CRC_BAD = 0;
  localparam int STAT_LEN_BAD = 1;
  localparam int STAT_RX_ER   = 2;

  localparam int          LEN_W     = 16;
  localparam int          DLY_DEPTH = 5;      // last payload byte + 4 FCS bytes
  localparam logic [2:0]  DLY_FULL  = 3'd5;
  localparam logic [2:0]  PRE_MAX   = 3'd7;   // longest accepted preamble

endpackage
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_byte
//  Purpose  : Combinational byte-parallel CRC-32 next-state (reflected,
//             polynomial EDB88320). No init or final XOR applied here.
//  Ports    : crc_in  [31:0] current CRC register
//             data    [7:0]  byte to absorb (LSB first on the wire)
//             crc_out [31:0] CRC register after absorbing data
//  Revision : 1.0 - initial release
// ============================================================================
module crc32_byte
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  always_comb begin
    w_c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (w_c[0]) w_c = (w_c >> 1) ^ CRC_POLY;
      else        w_c = w_c >> 1;
    end
    crc_out = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/gmii_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : gmii_rx_deframer
//  Purpose  : GMII receive frame extractor. Strips preamble/SFD, checks
//             FCS and length, drops the 4 FCS bytes and streams payload with
//             an end-of-frame marker, per-frame status and good/bad counters.
//  Ports    : RX_CLK, rst_n (async, active-low)
//             RXD[7:0], RX_DV, RX_ER          GMII receive inputs
//             out_data[7:0], out_valid, out_last  payload stream
//             status_valid, status[2:0]       {rx_er_seen, len_bad, crc_bad}
//             good_frames, bad_frames         saturating frame counters
//  Revision : 1.0 - initial release
// ============================================================================
module gmii_rx_deframer
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic              RX_CLK,
  input  logic              rst_n,
  input  logic [7:0]        RXD,
  input  logic              RX_DV,
  input  logic              RX_ER,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              status_valid,
  output logic [STAT_W-1:0] status,
  output logic [CNT_W-1:0]  good_frames,
  output logic [CNT_W-1:0]  bad_frames
);

  rx_state_t                       r_state, w_state_next;
  logic [2:0]                      r_pre_cnt, w_pre_cnt_next;
  logic                            w_shift, w_end;
  logic [31:0]                     r_crc, w_crc_next;
  logic [LEN_W-1:0]                r_len;
  logic [DLY_DEPTH-1:0][7:0]       r_dly;       // r_dly[DLY_DEPTH-1] is oldest
  logic [2:0]                      r_fill;
  logic                            r_rx_er;
  logic                            w_full;
  logic [STAT_W-1:0]               w_status;

  crc32_byte u_crc (
    .crc_in  (r_crc),
    .data    (RXD),
    .crc_out (w_crc_next)
  );

  // -------------------------------------------------------------------------
  // Framing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_DISCARD;
      r_pre_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_pre_cnt <= w_pre_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pre_cnt_next = r_pre_cnt;
    w_shift        = 1'b0;
    w_end          = 1'b0;
    case (r_state)
      ST_DISCARD: if (!RX_DV) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (RX_DV) begin
          if (RXD == SFD) begin
            w_state_next = ST_DATA;
          end else if (RXD == PRE) begin
            w_state_next   = ST_PREAMBLE;
            w_pre_cnt_next = 3'd1;
          end else begin
            w_state_next = ST_DISCARD;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!RX_DV) begin
          w_state_next = ST_IDLE;
        end else if (RXD == SFD) begin
          w_state_next = ST_DATA;
        end else if (RXD == PRE) begin
          if (r_pre_cnt == PRE_MAX) w_state_next = ST_DISCARD;
          else w_pre_cnt_next = r_pre_cnt + 3'd1;
        end else begin
          w_state_next = ST_DISCARD;
        end
      end
      ST_DATA: begin
        if (RX_DV) begin
          w_shift = 1'b1;
        end else begin
          w_end        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_DISCARD;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: CRC, length, FCS-stripping delay line, status
  // -------------------------------------------------------------------------
  // A full delay line means the oldest entry cannot be FCS, so it is payload.
  assign w_full = (r_fill == DLY_FULL);

  always_comb begin
    w_status               = '0;
    w_status[STAT_CRC_BAD] = (r_crc != CRC_RESIDUE);
    w_status[STAT_LEN_BAD] = (r_len < LEN_W'(MIN_LEN)) || (r_len > LEN_W'(MAX_LEN));
    w_status[STAT_RX_ER]   = r_rx_er;
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_crc        <= CRC_INIT;
      r_len        <= '0;
      r_dly        <= '0;
      r_fill       <= 3'd0;
      r_rx_er      <= 1'b0;
      out_data     <= 8'h00;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      status_valid <= 1'b0;
      status       <= '0;
    end else begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      status_valid <= 1'b0;
      if (w_shift) begin
        r_crc   <= w_crc_next;
        if (r_len != '1) r_len <= r_len + LEN_W'(1);
        r_dly   <= {r_dly[DLY_DEPTH-2:0], RXD};
        if (!w_full) r_fill <= r_fill + 3'd1;
        r_rx_er <= r_rx_er | RX_ER;
        if (w_full) begin
          out_valid <= 1'b1;
          out_data  <= r_dly[DLY_DEPTH-1];
        end
      end else if (w_end) begin
        if (w_full) begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          out_data  <= r_dly[DLY_DEPTH-1];
        end
        status_valid <= 1'b1;
        status       <= w_status;
        // Re-arm in the same cycle so a frame can follow after one idle cycle.
        r_crc   <= CRC_INIT;
        r_len   <= '0;
        r_dly   <= '0;
        r_fill  <= 3'd0;
        r_rx_er <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating frame counters, driven by the registered status pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      good_frames <= '0;
      bad_frames  <= '0;
    end else if (status_valid) begin
      if (status == '0) begin
        if (good_frames != '1) good_frames <= good_frames + CNT_W'(1);
      end else begin
        if (bad_frames != '1) bad_frames <= bad_frames + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
